vlc_bit_packer: RTL and testbench

//  Downstream of the component sequencer. Packs variable-length codewords (value, length)

---
 rtl/prores_pkg.sv | 9 +
 rtl/vlc_bit_packer_if.sv | 20 ++
 rtl/sync_fifo.sv | 51 +++++
 rtl/vlc_bit_packer.sv | 115 +++++++++++
 tb/tb_vlc_bit_packer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/prores_pkg.sv
// Shared encoder constants.
//  WORD_W      bitstream word width; also the maximum codeword length
//  LEN_W       width of a codeword-length field; must hold WORD_W
//  FIFO_DEPTH  default output FIFO depth for the bit packer (power of two)
package prores_pkg;
  localparam int WORD_W     = 32;
  localparam int LEN_W      = 6;
  localparam int FIFO_DEPTH = 4;
endpackage

// File: rtl/vlc_bit_packer_if.sv
// Codeword-in / word-out bus of the VLC bit packer.
//  in_enable/in_code/in_len/in_flush : codeword stream from the VLC coders (no backpressure)
//  out_valid/out_data/out_ready      : packed-word stream to the consumer
//  slave  : the packer side
//  master : the sequencer/consumer side
interface vlc_bit_packer_if;
  import prores_pkg::*;
  logic              in_enable;
  logic [WORD_W-1:0] in_code;
  logic [LEN_W-1:0]  in_len;
  logic              in_flush;
  logic              out_valid;
  logic [WORD_W-1:0] out_data;
  logic              out_ready;

  modport slave  (input  in_enable, in_code, in_len, in_flush, out_ready,
                  output out_valid, out_data);
  modport master (output in_enable, in_code, in_len, in_flush, out_ready,
                  input  out_valid, out_data);
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO.
//  clock, reset_n : clock, async active-low reset
//  clear          : synchronous empty
//  push/din       : write a word (accepted when not full, or when popping the same cycle)
//  pop            : discard the head (ignored when empty)
//  dout           : head word, 0 while empty
//  full/empty     : occupancy flags
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             wr_en, rd_en;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en && !clear) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/vlc_bit_packer.sv
// Packs right-aligned (code, len) VLC codewords into MSB-first WORD_W-bit words.
//  clock, reset_n : clock, async active-low reset
//  clear_n        : sync active-low clear from the sequencer
//  bus            : codeword input / packed-word output (vlc_bit_packer_if.slave)
//  flush_done     : one-cycle pulse when a flush has completed
//  bit_count      : codeword bits appended since reset/clear (pad excluded)
//  overflow       : sticky, a completed word was dropped on a full FIFO
module vlc_bit_packer
  import prores_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                clear_n,
  vlc_bit_packer_if.slave     bus,
  output logic                flush_done,
  output logic [31:0]         bit_count,
  output logic                overflow
);
  localparam int ACC_W = 2 * WORD_W;
  localparam logic [LEN_W:0]   WORD_L = WORD_W[LEN_W:0];
  localparam logic [LEN_W:0]   ACC_L  = ACC_W[LEN_W:0];
  localparam logic [LEN_W-1:0] LEN_MAX = WORD_W[LEN_W-1:0];

  typedef enum logic [1:0] {RUN, PAD, DONE} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;     // valid bits left-aligned at the MSB
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [LEN_W-1:0]   len_c;
  logic [LEN_W:0]     total, sh;
  logic [ACC_W-1:0]   code_ext, merged;
  logic               append, push, pop, fifo_full, fifo_empty;
  logic [WORD_W-1:0]  push_data;

  always_comb begin
    len_c    = (bus.in_len > LEN_MAX) ? LEN_MAX : bus.in_len;
    append   = (state_q == RUN) && bus.in_enable && (len_c != '0);
    code_ext = {{WORD_W{1'b0}}, bus.in_code} & ~({ACC_W{1'b1}} << len_c);
    total    = {1'b0, fill_q} + {1'b0, len_c};
    // Slot the new code just below the existing fill bits.
    sh       = ACC_L - total;
    merged   = acc_q | (code_ext << sh);

    state_d   = state_q;
    acc_d     = acc_q;
    fill_d    = fill_q;
    push      = 1'b0;
    push_data = acc_q[ACC_W-1 -: WORD_W];
    case (state_q)
      RUN: begin
        if (append) begin
          if (total >= WORD_L) begin
            push      = 1'b1;
            push_data = merged[ACC_W-1 -: WORD_W];
            acc_d     = merged << WORD_W;
            fill_d    = LEN_W'(total - WORD_L);
          end else begin
            acc_d  = merged;
            fill_d = total[LEN_W-1:0];
          end
        end
        if (bus.in_flush) state_d = PAD;
      end
      PAD: begin
        // Bits below the fill are already zero, so the head is the padded word.
        push    = (fill_q != '0);
        acc_d   = '0;
        fill_d  = '0;
        state_d = DONE;
      end
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign pop           = bus.out_valid & bus.out_ready;
  assign bus.out_valid = ~fifo_empty;
  assign flush_done    = (state_q == DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RUN;
      acc_q     <= '0;
      fill_q    <= '0;
      bit_count <= '0;
      overflow  <= 1'b0;
    end else if (!clear_n) begin
      state_q   <= RUN;
      acc_q     <= '0;
      fill_q    <= '0;
      bit_count <= '0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      fill_q    <= fill_d;
      if (append) bit_count <= bit_count + 32'(len_c);
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  sync_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (~clear_n),
    .push    (push),
    .pop     (pop),
    .din     (push_data),
    .dout    (bus.out_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );
endmodule

// File: tb/tb_vlc_bit_packer.sv
module tb_vlc_bit_packer;
  import prores_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n, clear_n;
  logic        flush_done, overflow;
  logic [31:0] bit_count;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] bc0;

  vlc_bit_packer_if bus ();

  vlc_bit_packer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear_n    (clear_n),
    .bus        (bus),
    .flush_done (flush_done),
    .bit_count  (bit_count),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic en, input logic [31:0] code, input logic [5:0] len,
                       input logic fl);
    bus.in_enable = en;
    bus.in_code   = code;
    bus.in_len    = len;
    bus.in_flush  = fl;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && !bus.out_valid) break;
      tick();
    end
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_empty"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  // Scoreboard: compare the head each cycle it will be accepted at the next edge.
  always @(negedge clock) begin
    if (reset_n && clear_n && bus.out_valid && bus.out_ready) begin
      n_chk++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL word_unexpected observed=%h expected=none", bus.out_data);
      end
      if (exp_q.size() != 0) chk("word", bus.out_data, exp_q.pop_front());
    end
  end

  initial begin
    reset_n = 1'b0;
    clear_n = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'd0, 6'd0, 1'b0);
    tick(); tick();
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_data", bus.out_data, 32'd0);
    chk("rst_bitcount", bit_count, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_flush_done", {31'd0, flush_done}, 32'd0);
    reset_n = 1'b1;
    tick();

    // 1: two 16-bit codes make one word
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h0000ABCD, 6'd16, 1'b0);
    tick();
    chk("pack_no_early_valid", {31'd0, bus.out_valid}, 32'd0);
    drive(1'b1, 32'h00001234, 6'd16, 1'b0);
    exp_q.push_back(32'hABCD1234);
    tick();
    chk("pack_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("pack_bitcount", bit_count, 32'd32);
    drive(1'b0, 32'd0, 6'd0, 1'b0);
    drain("pack");

    // 2: bits above in_len are masked; len 0 is a no-op
    bc0 = bit_count;
    drive(1'b1, 32'hFFFFFFFF, 6'd3, 1'b0);
    tick();
    drive(1'b1, 32'hFFFFFFFF, 6'd0, 1'b0);
    tick();
    chk("len0_bitcount", bit_count, bc0 + 32'd3);
    drive(1'b1, 32'h00000000, 6'd29, 1'b0);
    exp_q.push_back(32'hE0000000);
    tick();
    drive(1'b0, 32'd0, 6'd0, 1'b0);
    chk("mask_bitcount", bit_count, bc0 + 32'd32);
    drain("mask");

    // 3: flush pads the residual
    bc0 = bit_count;
    drive(1'b1, 32'h00000016, 6'd5, 1'b0);
    tick();
    drive(1'b0, 32'd0, 6'd0, 1'b1);
    exp_q.push_back(32'hB0000000);
    tick();
    drive(1'b1, 32'hFFFFFFFF, 6'd8, 1'b1);   // ignored in PAD
    chk("flush_pad_done", {31'd0, flush_done}, 32'd0);
    tick();
    drive(1'b0, 32'd0, 6'd0, 1'b0);
    chk("flush_done", {31'd0, flush_done}, 32'd1);
    chk("flush_valid", {31'd0, bus.out_valid}, 32'd1);
    tick();
    chk("flush_done_pulse", {31'd0, flush_done}, 32'd0);
    chk("flush_bitcount", bit_count, bc0 + 32'd5);
    drain("flush");

    // 3b: flush with nothing buffered
    drive(1'b0, 32'd0, 6'd0, 1'b1);
    tick();
    drive(1'b0, 32'd0, 6'd0, 1'b0);
    tick();
    chk("flush0_done", {31'd0, flush_done}, 32'd1);
    chk("flush0_noword", {31'd0, bus.out_valid}, 32'd0);
    tick();
    drain("flush0");

    // 4: append and flush in the same cycle, fill 28
    drive(1'b1, 32'h01234567, 6'd28, 1'b0);
    tick();
    drive(1'b1, 32'h000000A5, 6'd8, 1'b1);
    exp_q.push_back(32'h1234567A);
    exp_q.push_back(32'h50000000);
    tick();
    drive(1'b0, 32'd0, 6'd0, 1'b0);
    chk("aflush_valid", {31'd0, bus.out_valid}, 32'd1);
    tick();
    chk("aflush_done", {31'd0, flush_done}, 32'd1);
    drain("aflush");

    // 5: overflow with the consumer stalled
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'hC0DE0000 + 32'(i), 6'd32, 1'b0);
      if (i < 4) exp_q.push_back(32'hC0DE0000 + 32'(i));
      tick();
      if (i == 3) chk("ovf_not_yet", {31'd0, overflow}, 32'd0);
    end
    drive(1'b0, 32'd0, 6'd0, 1'b0);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    bus.out_ready = 1'b1;
    drain("ovf");
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    bus.out_ready = 1'b0;
    clear_n = 1'b0;
    tick();
    clear_n = 1'b1;
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);

    // 5b: push and pop together while full
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h5EED0000 + 32'(i), 6'd32, 1'b0);
      exp_q.push_back(32'h5EED0000 + 32'(i));
      tick();
    end
    drive(1'b1, 32'h5EED00FF, 6'd32, 1'b0);
    exp_q.push_back(32'h5EED00FF);
    bus.out_ready = 1'b1;
    tick();
    drive(1'b0, 32'd0, 6'd0, 1'b0);
    chk("pushpop_no_ovf", {31'd0, overflow}, 32'd0);
    drain("pushpop");

    // 6: clear during PAD with words queued
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h11111111, 6'd32, 1'b0);
    tick();
    drive(1'b1, 32'h22222222, 6'd32, 1'b0);
    tick();
    drive(1'b1, 32'h00000007, 6'd5, 1'b1);
    tick();
    drive(1'b0, 32'd0, 6'd0, 1'b0);
    clear_n = 1'b0;
    tick();
    clear_n = 1'b1;
    exp_q.delete();
    chk("clr_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("clr_bitcount", bit_count, 32'd0);
    chk("clr_overflow", {31'd0, overflow}, 32'd0);
    chk("clr_flush_done", {31'd0, flush_done}, 32'd0);
    tick();
    chk("clr_flush_done2", {31'd0, flush_done}, 32'd0);
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h0000BEEF, 6'd16, 1'b0);
    tick();
    drive(1'b1, 32'h0000CAFE, 6'd16, 1'b0);
    exp_q.push_back(32'hBEEFCAFE);
    tick();
    drive(1'b0, 32'd0, 6'd0, 1'b0);
    chk("clr_resume_bitcount", bit_count, 32'd32);
    drain("clr_resume");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
